plot_arbiter: RTL and testbench
===============================

PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameters: none; four requesters fixed (0 clear, 1 brick, 2 paddle, 3 ball).
REQ-002 clk  input  1  system clock, CLOCK_50 domain.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  per-requester draw request, level, held until done.
REQ-005 rx  input  32  packed 4x8 rectangle left x; requester i at [8i+7:8i].
REQ-006 ry  input  28  packed 4x7 rectangle top y; requester i at [7i+6:7i].
REQ-007 rw  input  32  packed 4x8 rectangle width in pixels, 0..160.
REQ-008 rh  input  28  packed 4x7 rectangle height in pixels, 0..120.
REQ-009 rcol  input  12  packed 4x3 fill colour.
REQ-010 grant  output  4  one-hot, high from LOAD through DRAW for the owner.
REQ-011 done  output  4  one-cycle pulse to the owner when its rectangle completes.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 x, y, colour, plot  output  8/7/3/1  pixel write port to vga_adapter.

Function
REQ-014 FSM states IDLE, LOAD, DRAW, DONE; one state per cycle except DRAW.
REQ-015 IDLE: if any req bit high, select winner and go to LOAD next cycle; else stay.
REQ-016 Arbitration round-robin: search starts at (last_owner+1) mod 4; last_owner resets to 3, so requester 0 wins first after reset.
REQ-017 LOAD: latch winner's rx, ry, rw, rh, rcol into internal registers; assert grant; plot=0.
REQ-018 Inputs change after LOAD shall not affect the rectangle in progress.
REQ-019 DRAW: row-major sweep, one pixel per cycle, x from rx to rx+rw-1 then y increments, starting at (rx,ry).
REQ-020 DRAW lasts exactly rw*rh cycles; last pixel (rx+rw-1, ry+rh-1) moves to DONE.
REQ-021 rw=0 or rh=0: LOAD goes directly to DONE, zero plot cycles.
REQ-022 Clipping: pixel with x>159 or y>119 keeps its cycle but drives plot=0; coordinate arithmetic 9-bit/8-bit internally, no wrap-around to screen origin.
REQ-023 plot=1 only in DRAW for in-bounds pixels; x, y, colour are registered, valid in the same cycle as plot.
REQ-024 DONE: done[owner]=1 for one cycle, grant=0, update last_owner, return to IDLE.
REQ-025 Requester deasserting req during DRAW: sweep still completes, done still pulses.
REQ-026 Minimum gap between two consecutive rectangles: 3 non-plot cycles (DONE, IDLE, LOAD).
REQ-027 Simultaneous requests resolve purely by REQ-016; no requester waits more than three other rectangles.

Reset
REQ-028 resetn low at any clock edge, including mid-DRAW: state=IDLE, grant=0, done=0, busy=0, plot=0, x=0, y=0, colour=0, last_owner=3, sweep counters 0.
REQ-029 Rectangle aborted by reset produces no done pulse; requester re-requests after reset.

Structure
REQ-030 Shared package holds SCREEN_W=160, SCREEN_H=120, requester index constants (REQ_CLEAR=0, REQ_BRICK=1, REQ_PADDLE=2, REQ_BALL=3) and FSM state encodings.
REQ-031 One sub-module rr_select (4-bit request, 2-bit last_owner -> one-hot winner, combinational) instantiated once.
REQ-032 Sweep counters and FSM live in plot_arbiter; no RAM or VGA timing logic inside.

Verification
REQ-033 After reset, req=4'b1111 all 2x2 at distinct positions -> grants in order 0,1,2,3, each 4 plot pulses, 4 done pulses.
REQ-034 Requester 2 rx=150, ry=100, rw=16, rh=4 -> 64 DRAW cycles, plot=1 only for x 150..159 (40 pixels).
REQ-035 Requester 0 rw=160, rh=120, colour 0 -> 19200 consecutive plot cycles covering every pixel once, done[0] on cycle after last.
REQ-036 Requester 3 rw=0 -> grant one cycle, no plot, done[3] two cycles after request seen.
REQ-037 resetn low on 10th DRAW cycle of a 16x4 brick -> next cycle plot=0, busy=0, no done; bench re-request completes fully.
REQ-038 Requester 1 changes rx from 32 to 64 during DRAW -> all plotted x remain in 32..47.

Source files
------------

// File: rtl/plot_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the four-requester rectangle plotter.
package plot_arbiter_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [1:0] REQ_CLEAR  = 2'd0;
   localparam logic [1:0] REQ_BRICK  = 2'd1;
   localparam logic [1:0] REQ_PADDLE = 2'd2;
   localparam logic [1:0] REQ_BALL   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DRAW = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (oh[i]) idx = 2'(i);
      return idx;
   endfunction

endpackage

// File: rtl/plot_arbiter_rr_select.sv
// Round-robin winner pick: search starts just after last_owner and wraps once.
module rr_select (
   input  logic [3:0] req,
   input  logic [1:0] last_owner,
   output logic [3:0] winner
);

   logic [1:0] idx;
   logic       found;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_owner + 2'(k);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates four rectangle-fill requesters onto one pixel write port, one pixel per cycle.
module plot_arbiter
   import plot_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  req,
   input  logic [31:0] rx,
   input  logic [27:0] ry,
   input  logic [31:0] rw,
   input  logic [27:0] rh,
   input  logic [11:0] rcol,
   output logic [3:0]  grant,
   output logic [3:0]  done,
   output logic        busy,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot
);

   state_t      state, state_nx;
   logic [1:0]  owner, last_owner;
   logic [3:0]  winner;
   logic [7:0]  base_x, w_q, cx, cx_nx;
   logic [6:0]  base_y, h_q, cy, cy_nx;
   logic [2:0]  col_q;
   logic [7:0]  sel_x, sel_w, src_x;
   logic [6:0]  sel_y, sel_h, src_y;
   logic [2:0]  sel_col, pix_col;
   logic [8:0]  pix_x;
   logic [7:0]  pix_y;
   logic        row_end, last_pix, pix_on;

   rr_select u_rr_select (
      .req        (req),
      .last_owner (last_owner),
      .winner     (winner)
   );

   assign sel_x   = rx[8*int'(owner) +: 8];
   assign sel_y   = ry[7*int'(owner) +: 7];
   assign sel_w   = rw[8*int'(owner) +: 8];
   assign sel_h   = rh[7*int'(owner) +: 7];
   assign sel_col = rcol[3*int'(owner) +: 3];

   assign row_end  = ({1'b0, cx} + 9'd1) == {1'b0, w_q};
   assign last_pix = row_end && (({1'b0, cy} + 8'd1) == {1'b0, h_q});

   always_comb begin
      state_nx = state;
      cx_nx    = cx;
      cy_nx    = cy;
      case (state)
         S_IDLE: if (|req) state_nx = S_LOAD;
         S_LOAD: begin
            cx_nx    = '0;
            cy_nx    = '0;
            state_nx = (sel_w == '0 || sel_h == '0) ? S_DONE : S_DRAW;
         end
         S_DRAW: begin
            if (last_pix) begin
               state_nx = S_DONE;
            end else if (row_end) begin
               cx_nx = '0;
               cy_nx = cy + 7'd1;
            end else begin
               cx_nx = cx + 8'd1;
            end
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Pixel registers are loaded one cycle ahead, so LOAD reads the live inputs directly.
   assign src_x   = (state == S_LOAD) ? sel_x   : base_x;
   assign src_y   = (state == S_LOAD) ? sel_y   : base_y;
   assign pix_col = (state == S_LOAD) ? sel_col : col_q;
   assign pix_x   = {1'b0, src_x} + {1'b0, cx_nx};
   assign pix_y   = {1'b0, src_y} + {1'b0, cy_nx};
   assign pix_on  = (state_nx == S_DRAW) && (pix_x < 9'(SCREEN_W)) && (pix_y < 8'(SCREEN_H));

   always_ff @(posedge clk) begin
      // NOTE: resetn is sampled on the clock edge only; sequential state uses <= throughout.
      if (!resetn) begin
         state      <= S_IDLE;
         owner      <= REQ_CLEAR;
         last_owner <= REQ_BALL;
         cx         <= '0;
         cy         <= '0;
         base_x     <= '0;
         base_y     <= '0;
         w_q        <= '0;
         h_q        <= '0;
         col_q      <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
      end else begin
         state <= state_nx;
         cx    <= cx_nx;
         cy    <= cy_nx;
         plot  <= pix_on;
         if (state == S_IDLE && |req) owner <= onehot_to_idx(winner);
         if (state == S_LOAD) begin
            base_x <= sel_x;
            base_y <= sel_y;
            w_q    <= sel_w;
            h_q    <= sel_h;
            col_q  <= sel_col;
         end
         if (state == S_DONE) last_owner <= owner;
         if (state_nx == S_DRAW) begin
            x      <= pix_x[7:0];
            y      <= pix_y[6:0];
            colour <= pix_col;
         end
      end
   end

   assign grant = (state == S_LOAD || state == S_DRAW) ? (4'b0001 << owner) : 4'b0000;
   assign done  = (state == S_DONE) ? (4'b0001 << owner) : 4'b0000;
   assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_plot_arbiter.sv
// Randomised and directed bench for plot_arbiter against a queue-based reference model.
module tb_plot_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [7:0]  bx [4];
   logic [7:0]  bw [4];
   logic [6:0]  by [4];
   logic [6:0]  bh [4];
   logic [2:0]  bc [4];
   logic [31:0] rx, rw;
   logic [27:0] ry, rh;
   logic [11:0] rcol;
   logic [3:0]  grant, done;
   logic        busy, plot;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;

   assign rx   = {bx[3], bx[2], bx[1], bx[0]};
   assign ry   = {by[3], by[2], by[1], by[0]};
   assign rw   = {bw[3], bw[2], bw[1], bw[0]};
   assign rh   = {bh[3], bh[2], bh[1], bh[0]};
   assign rcol = {bc[3], bc[2], bc[1], bc[0]};

   plot_arbiter dut (
      .clk    (clk),
      .resetn (resetn),
      .req    (req),
      .rx     (rx),
      .ry     (ry),
      .rw     (rw),
      .rh     (rh),
      .rcol   (rcol),
      .grant  (grant),
      .done   (done),
      .busy   (busy),
      .x      (x),
      .y      (y),
      .colour (colour),
      .plot   (plot)
   );

   always #5 clk = ~clk;

   typedef struct {
      int who;
      int px;
      int py;
      int col;
      int cyc;
   } pix_t;

   pix_t got_q[$];
   pix_t exp_q[$];
   int   done_q[$];
   int   exp_done_q[$];
   int   grant_cycles[4];
   int   done_cyc;
   int   cycle;
   int   checks;
   int   errors;
   int   model_last;

   function automatic int idx_of(input logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   // One clock of observation; a requester drops its request as soon as it sees done.
   task automatic step();
      pix_t p;
      @(negedge clk);
      cycle++;
      for (int i = 0; i < 4; i++)
         if (grant[i]) grant_cycles[i]++;
      if (plot) begin
         p.who = idx_of(grant);
         p.px  = int'(x);
         p.py  = int'(y);
         p.col = int'(colour);
         p.cyc = cycle;
         got_q.push_back(p);
      end
      if (done != 4'b0000) begin
         done_q.push_back(idx_of(done));
         done_cyc = cycle;
         req = req & ~done;
      end
   endtask

   task automatic clear_obs();
      got_q.delete();
      exp_q.delete();
      done_q.delete();
      exp_done_q.delete();
      for (int i = 0; i < 4; i++) grant_cycles[i] = 0;
      done_cyc = -1;
   endtask

   // Reference: pending set served round-robin, each rectangle swept row-major and clipped.
   task automatic model_run(input logic [3:0] pend);
      logic [3:0] p;
      int   pick;
      int   px, py;
      bit   found;
      pix_t e;
      p = pend;
      while (p != 4'b0000) begin
         found = 1'b0;
         pick  = 0;
         for (int k = 1; k <= 4; k++) begin
            if (!found && p[(model_last + k) % 4]) begin
               pick  = (model_last + k) % 4;
               found = 1'b1;
            end
         end
         p[pick]    = 1'b0;
         model_last = pick;
         exp_done_q.push_back(pick);
         for (int r = 0; r < int'(bh[pick]); r++) begin
            for (int c = 0; c < int'(bw[pick]); c++) begin
               px = int'(bx[pick]) + c;
               py = int'(by[pick]) + r;
               if (px < 160 && py < 120) begin
                  e.who = pick;
                  e.px  = px;
                  e.py  = py;
                  e.col = int'(bc[pick]);
                  e.cyc = 0;
                  exp_q.push_back(e);
               end
            end
         end
      end
   endtask

   function automatic int pix_diff();
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (got_q[i].who != exp_q[i].who || got_q[i].px != exp_q[i].px ||
             got_q[i].py != exp_q[i].py || got_q[i].col != exp_q[i].col)
            return i;
      if (got_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   function automatic int done_diff();
      int n;
      n = (done_q.size() < exp_done_q.size()) ? done_q.size() : exp_done_q.size();
      for (int i = 0; i < n; i++)
         if (done_q[i] != exp_done_q[i]) return i;
      if (done_q.size() != exp_done_q.size()) return n;
      return -1;
   endfunction

   task automatic run_until_idle(input int budget, input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(req == 4'b0000 && busy == 1'b0) && n < budget);
      checks++;
      if (!(req == 4'b0000 && busy == 1'b0)) begin
         errors++;
         $display("FAIL %s timeout: req=%b busy=%b after %0d cycles, required idle", name, req, busy, n);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      req    = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         bx[i] = '0; by[i] = '0; bw[i] = '0; bh[i] = '0; bc[i] = '0;
      end
      repeat (3) step();
      resetn     = 1'b1;
      model_last = 3;
      step();
      checks += 7;
      if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b required 0000", grant); end
      if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b required 0000", done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
      if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b required 0", plot); end
      if (x !== 8'd0) begin errors++; $display("FAIL reset_x got %0d required 0", x); end
      if (y !== 7'd0) begin errors++; $display("FAIL reset_y got %0d required 0", y); end
      if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d required 0", colour); end
   endtask

   task automatic test_all_four();
      int d;
      int cnt[4];
      clear_obs();
      for (int i = 0; i < 4; i++) begin
         bx[i] = 8'(10 + 20 * i);
         by[i] = 7'(5 + 10 * i);
         bw[i] = 8'd2;
         bh[i] = 7'd2;
         bc[i] = 3'(i + 1);
         cnt[i] = 0;
      end
      model_run(4'b1111);
      req = 4'b1111;
      run_until_idle(200, "all_four");
      d = pix_diff();
      checks++;
      if (d != -1) begin errors++; $display("FAIL all_four_pixels first difference at %0d: got %0d pixels, required %0d", d, got_q.size(), exp_q.size()); end
      d = done_diff();
      checks++;
      if (d != -1) begin errors++; $display("FAIL all_four_done_order first difference at %0d: got %0d dones, required %0d", d, done_q.size(), exp_done_q.size()); end
      foreach (got_q[i]) if (got_q[i].who >= 0) cnt[got_q[i].who]++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cnt[i] != 4) begin errors++; $display("FAIL all_four_plots[%0d] got %0d required 4", i, cnt[i]); end
      end
      for (int i = 1; i < got_q.size(); i++) begin
         if (got_q[i].who != got_q[i-1].who) begin
            checks++;
            if (got_q[i].cyc - got_q[i-1].cyc != 4) begin
               errors++;
               $display("FAIL all_four_gap got %0d cycles between rectangles, required 4", got_q[i].cyc - got_q[i-1].cyc);
            end
         end
      end
   endtask

   task automatic test_clip();
      int d;
      clear_obs();
      bx[2] = 8'd150; by[2] = 7'd100; bw[2] = 8'd16; bh[2] = 7'd4; bc[2] = 3'd5;
      model_run(4'b0100);
      req = 4'b0100;
      run_until_idle(200, "clip");
      d = pix_diff();
      checks += 3;
      if (d != -1) begin errors++; $display("FAIL clip_pixels first difference at %0d: got %0d pixels, required %0d", d, got_q.size(), exp_q.size()); end
      if (got_q.size() != 40) begin errors++; $display("FAIL clip_count got %0d required 40", got_q.size()); end
      if (grant_cycles[2] != 65) begin errors++; $display("FAIL clip_draw_len got %0d grant cycles required 65", grant_cycles[2]); end
   endtask

   task automatic test_zero();
      clear_obs();
      bx[3] = 8'd40; by[3] = 7'd40; bw[3] = 8'd0; bh[3] = 7'd5; bc[3] = 3'd7;
      model_run(4'b1000);
      req = 4'b1000;
      step();
      checks += 2;
      if (grant !== 4'b1000) begin errors++; $display("FAIL zero_load_grant got %b required 1000", grant); end
      if (done !== 4'b0000) begin errors++; $display("FAIL zero_load_done got %b required 0000", done); end
      step();
      checks += 2;
      if (done !== 4'b1000) begin errors++; $display("FAIL zero_done got %b required 1000", done); end
      if (grant !== 4'b0000) begin errors++; $display("FAIL zero_done_grant got %b required 0000", grant); end
      run_until_idle(20, "zero");
      checks++;
      if (got_q.size() != 0) begin errors++; $display("FAIL zero_plots got %0d required 0", got_q.size()); end
   endtask

   task automatic test_mid_reset();
      int d;
      clear_obs();
      bx[1] = 8'd20; by[1] = 7'd30; bw[1] = 8'd16; bh[1] = 7'd4; bc[1] = 3'd6;
      req = 4'b0010;
      step();
      repeat (10) step();
      checks++;
      if (got_q.size() != 10) begin errors++; $display("FAIL mid_reset_prefix got %0d plots required 10", got_q.size()); end
      resetn = 1'b0;
      step();
      checks += 4;
      if (plot !== 1'b0) begin errors++; $display("FAIL mid_reset_plot got %b required 0", plot); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b required 0", busy); end
      if (done !== 4'b0000) begin errors++; $display("FAIL mid_reset_done got %b required 0000", done); end
      if (grant !== 4'b0000) begin errors++; $display("FAIL mid_reset_grant got %b required 0000", grant); end
      resetn     = 1'b1;
      model_last = 3;
      clear_obs();
      model_run(4'b0010);
      run_until_idle(200, "mid_reset_retry");
      d = pix_diff();
      checks += 2;
      if (d != -1) begin errors++; $display("FAIL mid_reset_retry_pixels first difference at %0d: got %0d pixels, required %0d", d, got_q.size(), exp_q.size()); end
      if (done_diff() != -1) begin errors++; $display("FAIL mid_reset_retry_done got %0d dones required %0d", done_q.size(), exp_done_q.size()); end
   endtask

   task automatic test_input_change();
      int d, bad;
      clear_obs();
      bx[1] = 8'd32; by[1] = 7'd10; bw[1] = 8'd16; bh[1] = 7'd3; bc[1] = 3'd2;
      model_run(4'b0010);
      req = 4'b0010;
      repeat (5) step();
      bx[1] = 8'd64; by[1] = 7'd0; bw[1] = 8'd3; bc[1] = 3'd1;
      run_until_idle(200, "input_change");
      bad = 0;
      foreach (got_q[i]) if (got_q[i].px < 32 || got_q[i].px > 47) bad++;
      d = pix_diff();
      checks += 2;
      if (bad != 0) begin errors++; $display("FAIL input_change_x_range got %0d pixels outside 32..47 required 0", bad); end
      if (d != -1) begin errors++; $display("FAIL input_change_pixels first difference at %0d: got %0d pixels, required %0d", d, got_q.size(), exp_q.size()); end
   endtask

   task automatic test_full_screen();
      int  bad;
      int  n;
      byte hits [160][120];
      clear_obs();
      bx[0] = 8'd0; by[0] = 7'd0; bw[0] = 8'd160; bh[0] = 7'd120; bc[0] = 3'd0;
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++) hits[i][j] = 0;
      req = 4'b0001;
      run_until_idle(19400, "full_screen");
      n   = got_q.size();
      bad = 0;
      foreach (got_q[i]) begin
         if (got_q[i].px < 160 && got_q[i].py < 120 && got_q[i].col == 0) hits[got_q[i].px][got_q[i].py]++;
         else bad++;
      end
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++)
            if (hits[i][j] != 1) bad++;
      checks += 3;
      if (n != 19200) begin errors++; $display("FAIL full_count got %0d plots required 19200", n); end
      if (bad != 0) begin errors++; $display("FAIL full_coverage got %0d bad pixels required 0", bad); end
      if (n > 0 && (got_q[n-1].cyc - got_q[0].cyc != 19199 || done_cyc != got_q[n-1].cyc + 1)) begin
         errors++;
         $display("FAIL full_timing got span %0d done at +%0d required span 19199 done at +1",
                  got_q[n-1].cyc - got_q[0].cyc, done_cyc - got_q[n-1].cyc);
      end
      model_last = 0;
   endtask

   task automatic test_random();
      int         d;
      logic [3:0] pend;
      for (int round = 0; round < 8; round++) begin
         clear_obs();
         for (int i = 0; i < 4; i++) begin
            bx[i] = 8'($urandom_range(0, 170));
            by[i] = 7'($urandom_range(0, 127));
            bw[i] = 8'($urandom_range(0, 12));
            bh[i] = 7'($urandom_range(0, 6));
            bc[i] = 3'($urandom_range(0, 7));
         end
         pend = 4'($urandom_range(1, 15));
         model_run(pend);
         req = pend;
         run_until_idle(2000, "random");
         d = pix_diff();
         checks += 2;
         if (d != -1) begin errors++; $display("FAIL random_pixels round %0d first difference at %0d: got %0d pixels, required %0d", round, d, got_q.size(), exp_q.size()); end
         d = done_diff();
         if (d != -1) begin errors++; $display("FAIL random_done round %0d first difference at %0d: got %0d dones, required %0d", round, d, done_q.size(), exp_done_q.size()); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cycle  = 0;
      test_reset();
      test_all_four();
      test_clip();
      test_zero();
      test_mid_reset();
      test_input_change();
      test_full_screen();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
